// File: rtl/sub_bytes_iter_pkg.sv
// Shared AES datapath definitions: byte/state types, forward S-box table
// and the SubBytes stage FSM encoding.
package sub_bytes_iter_pkg;

    typedef logic [7:0] t_AESByte;

    // Indexed [col][row]; [0][0] occupies the least significant byte.
    typedef t_AESByte [3:0][3:0] t_opaque_AESState;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUSY = 2'd1,
        ST_DONE = 2'd2
    } t_SubBytesState;

    localparam t_AESByte SBOX [256] = '{
        8'h63, 8'h7c, 8'h77, 8'h7b, 8'hf2, 8'h6b, 8'h6f, 8'hc5, 8'h30, 8'h01, 8'h67, 8'h2b, 8'hfe, 8'hd7, 8'hab, 8'h76,
        8'hca, 8'h82, 8'hc9, 8'h7d, 8'hfa, 8'h59, 8'h47, 8'hf0, 8'had, 8'hd4, 8'ha2, 8'haf, 8'h9c, 8'ha4, 8'h72, 8'hc0,
        8'hb7, 8'hfd, 8'h93, 8'h26, 8'h36, 8'h3f, 8'hf7, 8'hcc, 8'h34, 8'ha5, 8'he5, 8'hf1, 8'h71, 8'hd8, 8'h31, 8'h15,
        8'h04, 8'hc7, 8'h23, 8'hc3, 8'h18, 8'h96, 8'h05, 8'h9a, 8'h07, 8'h12, 8'h80, 8'he2, 8'heb, 8'h27, 8'hb2, 8'h75,
        8'h09, 8'h83, 8'h2c, 8'h1a, 8'h1b, 8'h6e, 8'h5a, 8'ha0, 8'h52, 8'h3b, 8'hd6, 8'hb3, 8'h29, 8'he3, 8'h2f, 8'h84,
        8'h53, 8'hd1, 8'h00, 8'hed, 8'h20, 8'hfc, 8'hb1, 8'h5b, 8'h6a, 8'hcb, 8'hbe, 8'h39, 8'h4a, 8'h4c, 8'h58, 8'hcf,
        8'hd0, 8'hef, 8'haa, 8'hfb, 8'h43, 8'h4d, 8'h33, 8'h85, 8'h45, 8'hf9, 8'h02, 8'h7f, 8'h50, 8'h3c, 8'h9f, 8'ha8,
        8'h51, 8'ha3, 8'h40, 8'h8f, 8'h92, 8'h9d, 8'h38, 8'hf5, 8'hbc, 8'hb6, 8'hda, 8'h21, 8'h10, 8'hff, 8'hf3, 8'hd2,
        8'hcd, 8'h0c, 8'h13, 8'hec, 8'h5f, 8'h97, 8'h44, 8'h17, 8'hc4, 8'ha7, 8'h7e, 8'h3d, 8'h64, 8'h5d, 8'h19, 8'h73,
        8'h60, 8'h81, 8'h4f, 8'hdc, 8'h22, 8'h2a, 8'h90, 8'h88, 8'h46, 8'hee, 8'hb8, 8'h14, 8'hde, 8'h5e, 8'h0b, 8'hdb,
        8'he0, 8'h32, 8'h3a, 8'h0a, 8'h49, 8'h06, 8'h24, 8'h5c, 8'hc2, 8'hd3, 8'hac, 8'h62, 8'h91, 8'h95, 8'he4, 8'h79,
        8'he7, 8'hc8, 8'h37, 8'h6d, 8'h8d, 8'hd5, 8'h4e, 8'ha9, 8'h6c, 8'h56, 8'hf4, 8'hea, 8'h65, 8'h7a, 8'hae, 8'h08,
        8'hba, 8'h78, 8'h25, 8'h2e, 8'h1c, 8'ha6, 8'hb4, 8'hc6, 8'he8, 8'hdd, 8'h74, 8'h1f, 8'h4b, 8'hbd, 8'h8b, 8'h8a,
        8'h70, 8'h3e, 8'hb5, 8'h66, 8'h48, 8'h03, 8'hf6, 8'h0e, 8'h61, 8'h35, 8'h57, 8'hb9, 8'h86, 8'hc1, 8'h1d, 8'h9e,
        8'he1, 8'hf8, 8'h98, 8'h11, 8'h69, 8'hd9, 8'h8e, 8'h94, 8'h9b, 8'h1e, 8'h87, 8'he9, 8'hce, 8'h55, 8'h28, 8'hdf,
        8'h8c, 8'ha1, 8'h89, 8'h0d, 8'hbf, 8'he6, 8'h42, 8'h68, 8'h41, 8'h99, 8'h2d, 8'h0f, 8'hb0, 8'h54, 8'hbb, 8'h16
    };

endpackage

// File: rtl/sub_bytes_iter_sbox_lookup.sv
// Single forward S-box: purely combinational byte substitution.
module sbox_lookup
    import sub_bytes_iter_pkg::*;
(
    input  t_AESByte in_byte,
    output t_AESByte out_byte
);

    assign out_byte = SBOX[in_byte];

endmodule

// File: rtl/sub_bytes_iter.sv
// Iterative SubBytes: one column per cycle through four S-boxes, result
// held on a valid/ready output straight from the working register.
module sub_bytes_iter
    import sub_bytes_iter_pkg::*;
(
    input  logic             clk,
    input  logic             rst_n,
    input  logic             i_valid,
    output logic             i_ready,
    input  t_opaque_AESState i_state,
    output logic             o_valid,
    input  logic             o_ready,
    output t_opaque_AESState o_state
);

    t_SubBytesState   state_reg;
    t_SubBytesState   state_next;
    logic [1:0]       col_reg;
    t_opaque_AESState buf_reg;
    t_AESByte [3:0]   sub_col;
    logic             load;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_sbox
            sbox_lookup u_sbox (
                .in_byte  (buf_reg[col_reg][gi]),
                .out_byte (sub_col[gi])
            );
        end
    endgenerate

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            ST_IDLE: if (i_valid) state_next = ST_BUSY;
            ST_BUSY: if (col_reg == 2'd3) state_next = ST_DONE;
            ST_DONE: if (o_ready) state_next = i_valid ? ST_BUSY : ST_IDLE;
            default: state_next = ST_IDLE;
        endcase
    end

    // In DONE the slot frees up in the same edge the result is taken.
    always_comb begin
        i_ready = 1'b0;
        o_valid = 1'b0;
        case (state_reg)
            ST_IDLE: i_ready = 1'b1;
            ST_DONE: begin
                i_ready = o_ready;
                o_valid = 1'b1;
            end
            default: ;
        endcase
    end

    assign load = i_valid & i_ready;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            buf_reg <= '0;
            col_reg <= 2'd0;
        end else if (load) begin
            buf_reg <= i_state;
            col_reg <= 2'd0;
        end else if (state_reg == ST_BUSY) begin
            buf_reg[col_reg] <= sub_col;
            col_reg          <= col_reg + 2'd1;
        end
    end

    assign o_state = buf_reg;

endmodule

// File: tb/tb_sub_bytes_iter.sv
// Directed and randomized checks of sub_bytes_iter against an S-box model
// derived from GF(2^8) inversion plus the AES affine transform.
module tb_sub_bytes_iter;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         i_valid = 1'b0;
    logic         i_ready;
    logic [127:0] i_state = '0;
    logic         o_valid;
    logic         o_ready = 1'b1;
    logic [127:0] o_state;

    int checks = 0;
    int errors = 0;
    int cyc = 0;

    sub_bytes_iter dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .i_valid (i_valid),
        .i_ready (i_ready),
        .i_state (i_state),
        .o_valid (o_valid),
        .o_ready (o_ready),
        .o_state (o_state)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    initial begin
        #2000000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "watchdog");
    end

    function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p = 8'h00;
        logic [7:0] x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = x[7] ? ((x << 1) ^ 8'h1b) : (x << 1);
        end
        return p;
    endfunction

    function automatic logic [7:0] rotl(input logic [7:0] v, input int n);
        return (v << n) | (v >> (8 - n));
    endfunction

    function automatic logic [7:0] sbox_ref(input logic [7:0] b);
        logic [7:0] inv = 8'h00;
        for (int x = 1; x < 256; x++)
            if (b != 8'h00 && gmul(b, 8'(x)) == 8'h01) inv = 8'(x);
        return inv ^ rotl(inv, 1) ^ rotl(inv, 2) ^ rotl(inv, 3) ^ rotl(inv, 4) ^ 8'h63;
    endfunction

    function automatic logic [127:0] state_ref(input logic [127:0] s);
        logic [127:0] r;
        for (int i = 0; i < 16; i++) r[8*i +: 8] = sbox_ref(s[8*i +: 8]);
        return r;
    endfunction

    function automatic logic [127:0] fill(input logic [7:0] b);
        return {16{b}};
    endfunction

    task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Accept one state, expect result after exactly 4 cycles, optionally stall.
    task automatic run_txn(input string tag, input logic [127:0] st,
                           input logic [127:0] exp, input int stall);
        int lat;
        logic [127:0] held;
        i_state = st;
        i_valid = 1'b1;
        o_ready = (stall == 0);
        check({tag, "_iready"}, 128'(i_ready), 128'(1));
        tick();
        i_valid = 1'b0;
        i_state = {$urandom, $urandom, $urandom, $urandom};
        lat = 0;
        while (!o_valid && lat < 20) begin
            tick();
            lat++;
        end
        check({tag, "_latency"}, 128'(lat), 128'(4));
        check({tag, "_data"}, o_state, exp);
        held = o_state;
        for (int k = 0; k < stall; k++) begin
            tick();
            check({tag, "_hold_valid"}, 128'(o_valid), 128'(1));
            check({tag, "_hold_data"}, o_state, held);
            check({tag, "_hold_iready"}, 128'(i_ready), 128'(0));
        end
        o_ready = 1'b1;
        #1;
        check({tag, "_done_iready"}, 128'(i_ready), 128'(1));
        tick();
        check({tag, "_one_xfer"}, 128'(o_valid), 128'(0));
    endtask

    initial begin
        logic [7:0]   fips_in  [16] = '{8'h19, 8'h3d, 8'he3, 8'hbe, 8'ha0, 8'hf4, 8'he2, 8'h2b,
                                        8'h9a, 8'hc6, 8'h8d, 8'h2a, 8'he9, 8'hf8, 8'h48, 8'h08};
        logic [7:0]   fips_out [16] = '{8'hd4, 8'h27, 8'h11, 8'hae, 8'he0, 8'hbf, 8'h98, 8'hf1,
                                        8'hb8, 8'hb4, 8'h5d, 8'he5, 8'h1e, 8'h41, 8'h52, 8'h30};
        logic [127:0] vin, vexp, rnd;
        int first_cyc, lat;

        // Reset
        repeat (3) tick();
        check("rst_iready", 128'(i_ready), 128'(1));
        check("rst_ovalid", 128'(o_valid), 128'(0));
        check("rst_ostate", o_state, 128'(0));
        rst_n = 1'b1;
        for (int k = 0; k < 10; k++) begin
            i_state = {$urandom, $urandom, $urandom, $urandom};
            tick();
            check("idle_ovalid", 128'(o_valid), 128'(0));
            check("idle_ostate", o_state, 128'(0));
            check("idle_iready", 128'(i_ready), 128'(1));
        end

        // Single-byte values
        run_txn("all00", fill(8'h00), fill(8'h63), 0);
        run_txn("all53", fill(8'h53), fill(8'hed), 0);
        run_txn("allff", fill(8'hff), fill(8'h16), 0);

        // FIPS-197 Appendix B round 1
        for (int i = 0; i < 16; i++) begin
            vin[8*i +: 8]  = fips_in[i];
            vexp[8*i +: 8] = fips_out[i];
        end
        run_txn("fips", vin, vexp, 0);

        // Backpressure
        rnd = {$urandom, $urandom, $urandom, $urandom};
        run_txn("bp", rnd, state_ref(rnd), 7);

        // Back-to-back with i_valid held high
        o_ready = 1'b1;
        i_valid = 1'b1;
        i_state = fill(8'h01);
        tick();
        i_state = fill(8'h00);
        lat = 0;
        while (!o_valid && lat < 20) begin
            tick();
            lat++;
        end
        first_cyc = cyc;
        check("b2b_first_latency", 128'(lat), 128'(4));
        check("b2b_first_data", o_state, fill(8'h7c));
        check("b2b_first_iready", 128'(i_ready), 128'(1));
        tick();
        i_valid = 1'b0;
        lat = 0;
        while (!o_valid && lat < 20) begin
            tick();
            lat++;
        end
        check("b2b_interval", 128'(cyc - first_cyc), 128'(5));
        check("b2b_second_data", o_state, fill(8'h63));
        tick();
        check("b2b_end", 128'(o_valid), 128'(0));

        // Reset during BUSY
        i_state = {$urandom, $urandom, $urandom, $urandom};
        i_valid = 1'b1;
        tick();
        i_valid = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        #1;
        check("midrst_ovalid", 128'(o_valid), 128'(0));
        check("midrst_ostate", o_state, 128'(0));
        check("midrst_iready", 128'(i_ready), 128'(1));
        tick();
        rst_n = 1'b1;
        for (int k = 0; k < 6; k++) begin
            tick();
            check("postrst_ovalid", 128'(o_valid), 128'(0));
        end
        rnd = {$urandom, $urandom, $urandom, $urandom};
        run_txn("postrst", rnd, state_ref(rnd), 0);

        // Randomized transactions with random stalls
        for (int t = 0; t < 20; t++) begin
            rnd = {$urandom, $urandom, $urandom, $urandom};
            run_txn("rand", rnd, state_ref(rnd), int'($urandom_range(0, 3)));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
